// File: rtl/serial_summator_pkg.sv
// Shared constants and full-adder helper functions for the bit-serial summator.
package serial_summator_pkg;

    // Operand width used when the instantiating design does not override it.
    localparam int unsigned DEFAULT_REGLENGTH = 32'd3;

    // Sum bit of a one-bit full adder.
    function automatic logic fa_sum(input logic a, input logic b, input logic cin);
        return a ^ b ^ cin;
    endfunction

    // Carry bit of a one-bit full adder: majority of the three inputs.
    function automatic logic fa_carry(input logic a, input logic b, input logic cin);
        return (a & b) | (a & cin) | (b & cin);
    endfunction

endpackage : serial_summator_pkg

// File: rtl/summator_fa.sv
// Purely combinational one-bit full adder used by the serial summator.
module summator_fa
    import serial_summator_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = fa_sum(a, b, cin);
    assign cout = fa_carry(a, b, cin);

endmodule : summator_fa

// File: rtl/serial_summator.sv
// Bit-serial unsigned adder. Operands arrive LSB first, one bit per clock;
// each full-adder result bit is pushed through a reglength-stage delay line
// and the last stage drives the serial sum output. A zero pad bit after each
// word emits the final carry and leaves the carry flop cleared, so words can
// be sent back to back without any framing.
module serial_summator
    import serial_summator_pkg::*;
#(
    parameter int unsigned reglength = DEFAULT_REGLENGTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic r1,
    input  logic r2,
    output logic sum
);

    logic                 w_s;
    logic                 w_cout;
    logic                 r_carry;
    logic [reglength-1:0] r_delay;

    summator_fa u_fa (
        .a    (r1),
        .b    (r2),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_cout)
    );

    // Carry flop: holds the carry into the next bit position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_carry <= 1'b0;
        end else begin
            r_carry <= w_cout;
        end
    end

    // Delay line: stage 0 captures the fresh sum bit, later stages shift it along.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_delay <= {reglength{1'b0}};
        end else begin
            r_delay[0] <= w_s;
            for (int i = 1; i < int'(reglength); i++) begin
                r_delay[i] <= r_delay[i-1];
            end
        end
    end

    // The last delay stage is a flop, so the serial output is registered.
    assign sum = r_delay[reglength-1];

endmodule : serial_summator

// File: tb/tb_serial_summator.sv
// Directed and randomized bench for serial_summator at reglength 3 and 1.
// Expected results come from integer addition modulo 2^(L+1); the serial
// output stream is reassembled at the documented latency and compared.
module tb_serial_summator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic a3, b3, s3;
    logic a1, b1, s1;

    serial_summator #(.reglength(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .r1    (a3),
        .r2    (b3),
        .sum   (s3)
    );

    serial_summator #(.reglength(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .r1    (a1),
        .r2    (b1),
        .sum   (s1)
    );

    typedef struct {
        int len;
        int base;
        int expv;
        int opa;
        int opb;
    } pend_t;

    int    n_tests = 0;
    int    n_fail  = 0;
    logic  samp3[$];
    logic  samp1[$];
    pend_t pend[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // One clock edge: inputs are set while no edge is pending, output sampled 1 time unit after.
    task automatic step(input logic x3, input logic y3, input logic x1, input logic y1);
        a3 = x3;
        b3 = y3;
        a1 = x1;
        b1 = y1;
        @(posedge clk);
        #1;
        samp3.push_back(s3);
        samp1.push_back(s1);
    endtask

    // Stream one word of width len into the matching DUT, followed by npad zero edges.
    task automatic word(input int len, input int a, input int b, input int npad);
        pend_t p;
        p.len  = len;
        p.base = samp3.size();
        p.expv = (a + b) % (1 << (len + 1));
        p.opa  = a;
        p.opb  = b;
        for (int k = 0; k < len; k++) begin
            if (len == 3) step(a[k], b[k], 1'b0, 1'b0);
            else          step(1'b0, 1'b0, a[k], b[k]);
        end
        repeat (npad) step(1'b0, 1'b0, 1'b0, 1'b0);
        pend.push_back(p);
    endtask

    // Flush the pipelines and compare every outstanding word.
    task automatic settle();
        logic [31:0] val;
        string       tag;
        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0);
        foreach (pend[w]) begin
            val = 32'd0;
            for (int b = 0; b <= pend[w].len; b++) begin
                if (pend[w].len == 3) val[b] = samp3[pend[w].base + pend[w].len - 1 + b];
                else                  val[b] = samp1[pend[w].base + pend[w].len - 1 + b];
            end
            tag = $sformatf("word_L%0d_%0d+%0d", pend[w].len, pend[w].opa, pend[w].opb);
            check_val(tag, val, pend[w].expv);
        end
        pend.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        a3 = 1'b0; b3 = 1'b0; a1 = 1'b0; b1 = 1'b0;
        #12;
        check_val("reset_sum_L3", {31'd0, s3}, 32'd0);
        check_val("reset_sum_L1", {31'd0, s1}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset: output must stay low.
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            check_val("idle_L3", {31'd0, s3}, 32'd0);
            check_val("idle_L1", {31'd0, s1}, 32'd0);
        end

        // Directed reglength=3 words.
        word(3, 3, 5, 1);
        word(3, 7, 7, 1);
        settle();

        // Exhaustive 1..7 x 1..7 back to back with a single pad.
        for (int i = 1; i < 8; i++)
            for (int j = 1; j < 8; j++)
                word(3, i, j, 1);
        settle();

        // Random words with random pad length.
        for (int n = 0; n < 40; n++)
            word(3, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(1, 3)));
        settle();

        // reglength=1 words: directed 1+1 then random.
        word(1, 1, 1, 1);
        for (int n = 0; n < 8; n++)
            word(1, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), int'($urandom_range(1, 2)));
        settle();

        // 7+7: after the pad edge the output carries result bit 1 (=1); reset clears it at once.
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check_val("pre_reset_bit1", {31'd0, s3}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_reset_sum", {31'd0, s3}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset after two data bits of 7+7, then 1+1 must read 2 with no leaked carry.
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("midword_reset_sum", {31'd0, s3}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        word(3, 1, 1, 1);
        settle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_serial_summator
